// File: rtl/syn_gpu_pkg.sv
// Shared widths and pixel payload types for the GPU pixel-transfer path.
package syn_gpu_pkg;

    localparam int unsigned P_X_W   = 11;
    localparam int unsigned P_Y_W   = 10;
    localparam int unsigned P_16B_W = 16;
    localparam int unsigned P_C_W   = 8;

    typedef struct packed {
        logic [P_C_W-1:0] y;
        logic [P_C_W-1:0] cb;
        logic [P_C_W-1:0] cr;
    } pxl_ycbcr_t;

endpackage

// File: rtl/syn_gpu_line_rasterizer.sv
// Bresenham line rasterizer: turns one line job into a stream of pixel beats
// on the master side of the pixel-transfer interface.
module syn_gpu_line_rasterizer
    import syn_gpu_pkg::*;
#(
    parameter int unsigned WIDTHX = P_X_W,
    parameter int unsigned WIDTHY = P_Y_W
) (
    input  logic                  clk_ir,
    input  logic                  rst_il,
    input  logic                  line_start,
    input  logic [WIDTHX-1:0]     line_x0,
    input  logic [WIDTHX-1:0]     line_x1,
    input  logic [WIDTHY-1:0]     line_y0,
    input  logic [WIDTHY-1:0]     line_y1,
    input  pxl_ycbcr_t            line_pxl,
    input  logic                  line_abort,
    output logic                  busy,
    output logic                  line_done,
    output pxl_ycbcr_t            pxl,
    output logic                  pxl_wr_valid,
    output logic                  pxl_rd_valid,
    output logic [WIDTHX-1:0]     posx,
    output logic [WIDTHY-1:0]     posy,
    output logic [P_16B_W-1:0]    misc_info_dist,
    output logic [P_16B_W-1:0]    misc_info_norm,
    input  logic                  ready
);

    localparam int unsigned W = ((WIDTHX > WIDTHY) ? WIDTHX : WIDTHY) + 2;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW} state_t;

    state_t              state;
    logic [WIDTHX-1:0]   x0_q, x1_q;
    logic [WIDTHY-1:0]   y0_q, y1_q;
    logic signed [W-1:0] dx_q, dy_q, err;
    logic                sx_neg, sy_neg;

    logic signed [W-1:0] x0_s, x1_s, y0_s, y1_s, diff_x, diff_y, abs_x, abs_y;
    logic signed [W:0]   e2, dx_ext, dy_ext;
    logic signed [W-1:0] err_nxt;
    logic                step_x, step_y, at_end, accept;
    logic [WIDTHX-1:0]   posx_nxt;
    logic [WIDTHY-1:0]   posy_nxt;

    assign pxl_rd_valid   = 1'b0;
    assign misc_info_dist = '0;
    assign misc_info_norm = '0;

    // Deltas and next Bresenham step, all evaluated from registered state.
    always_comb begin
        x0_s   = signed'(W'(x0_q));
        x1_s   = signed'(W'(x1_q));
        y0_s   = signed'(W'(y0_q));
        y1_s   = signed'(W'(y1_q));
        diff_x = x1_s - x0_s;
        diff_y = y1_s - y0_s;
        abs_x  = (diff_x < 0) ? -diff_x : diff_x;
        abs_y  = (diff_y < 0) ? -diff_y : diff_y;

        e2      = {err, 1'b0};
        dx_ext  = {dx_q[W-1], dx_q};
        dy_ext  = {dy_q[W-1], dy_q};
        step_x  = (e2 >= dy_ext);
        step_y  = (e2 <= dx_ext);
        err_nxt = err;
        if (step_x) err_nxt = err_nxt + dy_q;
        if (step_y) err_nxt = err_nxt + dx_q;

        posx_nxt = posx;
        posy_nxt = posy;
        if (step_x) posx_nxt = sx_neg ? (posx - WIDTHX'(1)) : (posx + WIDTHX'(1));
        if (step_y) posy_nxt = sy_neg ? (posy - WIDTHY'(1)) : (posy + WIDTHY'(1));

        at_end = (posx == x1_q) && (posy == y1_q);
        accept = pxl_wr_valid && ready;
    end

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            line_done    <= 1'b0;
            pxl_wr_valid <= 1'b0;
            posx         <= '0;
            posy         <= '0;
            pxl          <= '0;
            err          <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            sx_neg       <= 1'b0;
            sy_neg       <= 1'b0;
            x0_q         <= '0;
            x1_q         <= '0;
            y0_q         <= '0;
            y1_q         <= '0;
        end else begin
            line_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (line_start) begin
                        x0_q  <= line_x0;
                        x1_q  <= line_x1;
                        y0_q  <= line_y0;
                        y1_q  <= line_y1;
                        pxl   <= line_pxl;
                        busy  <= 1'b1;
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (line_abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        dx_q         <= abs_x;
                        dy_q         <= -abs_y;
                        sx_neg       <= (diff_x < 0);
                        sy_neg       <= (diff_y < 0);
                        err          <= abs_x - abs_y;
                        posx         <= x0_q;
                        posy         <= y0_q;
                        pxl_wr_valid <= 1'b1;
                        state        <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    // Abort wins over completion; a beat accepted this cycle still counts.
                    if (line_abort) begin
                        pxl_wr_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= S_IDLE;
                    end else if (accept) begin
                        if (at_end) begin
                            pxl_wr_valid <= 1'b0;
                            busy         <= 1'b0;
                            line_done    <= 1'b1;
                            state        <= S_IDLE;
                        end else begin
                            err  <= err_nxt;
                            posx <= posx_nxt;
                            posy <= posy_nxt;
                        end
                    end
                end
                default: begin
                    pxl_wr_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule
